// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: sequencing controller for the 5-stage pipeline.
// Each cycle it decides whether the front end advances, takes a bubble
// (load-use), is flushed (taken branch) or is frozen (data-memory wait).
// It also keeps a saturating stall-cycle counter and a memory-wait watchdog
// that parks the pipeline in ERROR until reset.
module hazard_stall_ctrl #(
  parameter int MAX_WAIT = 64,  // wait cycles tolerated before ERROR (>= 2)
  parameter int CNT_W    = 16   // width of stall_cnt_o
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rd_i,
  input  logic [4:0]       IFID_Rs1_i,
  input  logic [4:0]       IFID_Rs2_i,
  input  logic             BranchTaken_i,
  input  logic             MemReq_i,
  input  logic             MemAck_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IFID_Flush_o,
  output logic             IsHazzard_o,
  output logic             PipeStall_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10,
    ERROR    = 2'b11
  } state_t;

  // waitCnt never exceeds MAX_WAIT-1, so clog2(MAX_WAIT) bits are enough.
  localparam int                WAIT_W    = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] waitLimit = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  cntMax    = '1;

  state_t            state;
  logic [WAIT_W-1:0] waitCnt;
  logic [CNT_W-1:0]  stallCnt;
  logic              timeoutFlag;

  logic loadUseHaz;
  logic memMiss;

  // A load in EX feeding either source of the instruction in ID; x0 never hazards.
  assign loadUseHaz = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                      ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));

  // A memory access that did not complete in its issue cycle.
  assign memMiss = MemReq_i && !MemAck_i;

  // Pipeline control decode: state plus same-cycle hazard inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    PCWrite_o    = 1'b0;
    IFID_Write_o = 1'b0;
    IFID_Flush_o = 1'b0;
    IsHazzard_o  = 1'b0;
    PipeStall_o  = 1'b0;
    unique case (state)
      IDLE: begin
        IsHazzard_o = 1'b1;
      end
      RUN: begin
        if (memMiss) begin
          // Freeze everything; hazards and branches are re-evaluated later.
          PipeStall_o = 1'b1;
        end else if (loadUseHaz) begin
          // One bubble; branch operands are stale so the branch is ignored.
          IsHazzard_o = 1'b1;
        end else if (BranchTaken_i) begin
          PCWrite_o    = 1'b1;
          IFID_Write_o = 1'b1;
          IFID_Flush_o = 1'b1;
        end else begin
          PCWrite_o    = 1'b1;
          IFID_Write_o = 1'b1;
        end
      end
      MEM_WAIT, ERROR: begin
        // Freeze, not bubble: the zeroing mux stays deselected.
        PipeStall_o = 1'b1;
      end
      default: begin
        IsHazzard_o = 1'b1;
      end
    endcase
  end

  // Sequencing FSM with the memory-wait watchdog and sticky timeout flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      waitCnt     <= '0;
      timeoutFlag <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples values from before this edge, independent of statement order.
      unique case (state)
        IDLE: begin
          if (start_i) state <= RUN;
        end
        RUN: begin
          if (memMiss) begin
            state   <= MEM_WAIT;
            waitCnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          // Only the ack ends a wait; a late ack on the limit cycle still wins.
          if (MemAck_i) begin
            state   <= RUN;
            waitCnt <= '0;
          end else if (waitCnt == waitLimit) begin
            state       <= ERROR;
            timeoutFlag <= 1'b1;
          end else begin
            waitCnt <= waitCnt + WAIT_W'(1);
          end
        end
        ERROR: begin
          // Parked until reset.
          timeoutFlag <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Saturating count of front-end stall cycles while executing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stallCnt <= '0;
    end else if (((state == RUN) || (state == MEM_WAIT)) && !PCWrite_o &&
                 (stallCnt != cntMax)) begin
      stallCnt <= stallCnt + CNT_W'(1);
    end
  end

  assign state_o     = state;
  assign stall_cnt_o = stallCnt;
  assign timeout_o   = timeoutFlag;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a cycle-level reference model.
module tb_hazard_stall_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_Rd_i;
  logic [4:0]       IFID_Rs1_i;
  logic [4:0]       IFID_Rs2_i;
  logic             BranchTaken_i;
  logic             MemReq_i;
  logic             MemAck_i;
  logic             PCWrite_o;
  logic             IFID_Write_o;
  logic             IFID_Flush_o;
  logic             IsHazzard_o;
  logic             PipeStall_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             timeout_o;

  hazard_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_Rd_i      (IDEX_Rd_i),
    .IFID_Rs1_i     (IFID_Rs1_i),
    .IFID_Rs2_i     (IFID_Rs2_i),
    .BranchTaken_i  (BranchTaken_i),
    .MemReq_i       (MemReq_i),
    .MemAck_i       (MemAck_i),
    .PCWrite_o      (PCWrite_o),
    .IFID_Write_o   (IFID_Write_o),
    .IFID_Flush_o   (IFID_Flush_o),
    .IsHazzard_o    (IsHazzard_o),
    .PipeStall_o    (PipeStall_o),
    .state_o        (state_o),
    .stall_cnt_o    (stall_cnt_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int passCnt  = 0;
  int checkCnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: mode 0=idle 1=run 2=waiting 3=error; waited counts the
  // unacknowledged cycles of the current access, request cycle included.
  int mMode    = 0;
  int mWaited  = 0;
  int mStall   = 0;
  bit mTimeout = 0;

  function automatic bit modelLoadUse();
    return IDEX_MemRead_i && (IDEX_Rd_i != 0) &&
           (IDEX_Rd_i == IFID_Rs1_i || IDEX_Rd_i == IFID_Rs2_i);
  endfunction

  // Expected {PCWrite, IFID_Write, IFID_Flush, IsHazzard, PipeStall}.
  function automatic logic [4:0] expCtrl();
    if (mMode == 0) return 5'b00010;
    if (mMode != 1) return 5'b00001;
    if (MemReq_i && !MemAck_i) return 5'b00001;
    if (modelLoadUse()) return 5'b00010;
    if (BranchTaken_i) return 5'b11100;
    return 5'b11000;
  endfunction

  task automatic modelReset();
    mMode = 0; mWaited = 0; mStall = 0; mTimeout = 0;
  endtask

  task automatic modelStep();
    logic [4:0] c;
    c = expCtrl();
    if ((mMode == 1 || mMode == 2) && !c[4] && mStall < CNT_MAX) mStall++;
    case (mMode)
      0: if (start_i) mMode = 1;
      1: if (MemReq_i && !MemAck_i) begin mMode = 2; mWaited = 1; end
      2: begin
        if (MemAck_i) begin
          mMode = 1; mWaited = 0;
        end else begin
          mWaited++;
          if (mWaited == MAX_WAIT) begin mMode = 3; mTimeout = 1; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic clearIn();
    start_i = 0; IDEX_MemRead_i = 0; IDEX_Rd_i = 0; IFID_Rs1_i = 0; IFID_Rs2_i = 0;
    BranchTaken_i = 0; MemReq_i = 0; MemAck_i = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic runCycle(input string tag);
    if (rst_i) modelReset();
    #1;
    check({tag, ".ctrl"}, {27'b0, PCWrite_o, IFID_Write_o, IFID_Flush_o, IsHazzard_o, PipeStall_o},
          {27'b0, expCtrl()});
    check({tag, ".state"}, {30'b0, state_o}, 32'(mMode));
    check({tag, ".stall"}, {28'b0, stall_cnt_o}, 32'(mStall));
    check({tag, ".timeout"}, {31'b0, timeout_o}, {31'b0, mTimeout});
    @(posedge clk_i);
    if (rst_i) modelReset();
    else modelStep();
    @(negedge clk_i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, limit 2000000");
    $fatal(1);
  end

  initial begin
    clearIn();
    rst_i = 1;
    @(negedge clk_i);
    runCycle("reset");
    rst_i = 0;
    runCycle("idle");
    check("idle_haz", {31'b0, IsHazzard_o}, 32'd1);
    check("idle_pcw", {31'b0, PCWrite_o}, 32'd0);

    // Start pulse: RUN one cycle later.
    start_i = 1; runCycle("start");
    start_i = 0;
    check("start_state", {30'b0, state_o}, 32'd1);

    // Load-use on rs2 gives exactly one bubble.
    IDEX_MemRead_i = 1; IDEX_Rd_i = 5; IFID_Rs2_i = 5;
    #1;
    check("lu_haz", {29'b0, IsHazzard_o, PCWrite_o, IFID_Write_o}, 32'b100);
    #1;
    runCycle("lu");
    clearIn(); runCycle("lu_next");
    check("lu_stall_cnt", {28'b0, stall_cnt_o}, 32'd1);

    // x0 destination never hazards.
    IDEX_MemRead_i = 1; IDEX_Rd_i = 0; IFID_Rs1_i = 0; runCycle("x0");
    // Load-use suppresses a taken branch.
    clearIn(); IDEX_MemRead_i = 1; IDEX_Rd_i = 7; IFID_Rs1_i = 7; BranchTaken_i = 1;
    #1;
    check("lu_br", {30'b0, IFID_Flush_o, IsHazzard_o}, 32'b01);
    #1;
    runCycle("lu_br");
    // Taken branch alone flushes.
    clearIn(); BranchTaken_i = 1; runCycle("branch");
    // Request and ack together: no stall.
    clearIn(); MemReq_i = 1; MemAck_i = 1; runCycle("req_ack");

    // Memory access acked three cycles after the request; request drops early.
    clearIn(); MemReq_i = 1; runCycle("mw_req");
    MemReq_i = 0; runCycle("mw_1");
    runCycle("mw_2");
    MemAck_i = 1; runCycle("mw_ack");
    clearIn();
    check("mw_back_run", {30'b0, state_o}, 32'd1);
    check("mw_stall_cnt", {28'b0, stall_cnt_o}, 32'd6);
    runCycle("mw_after");

    // Watchdog: no ack for MAX_WAIT cycles reaches ERROR.
    MemReq_i = 1;
    for (int i = 0; i < MAX_WAIT; i++) runCycle("wd");
    check("wd_state", {30'b0, state_o}, 32'd3);
    check("wd_timeout", {31'b0, timeout_o}, 32'd1);
    MemReq_i = 0; MemAck_i = 1; start_i = 1; runCycle("err_hold");
    clearIn(); runCycle("err_hold2");

    // Asynchronous reset, checked before any clock edge.
    #2;
    rst_i = 1;
    #1;
    check("async_state", {30'b0, state_o}, 32'd0);
    check("async_timeout", {31'b0, timeout_o}, 32'd0);
    modelReset();
    @(negedge clk_i);
    runCycle("post_rst");
    rst_i = 0;

    // Saturation: 20 back-to-back load-use stalls.
    start_i = 1; runCycle("sat_start");
    clearIn(); IDEX_MemRead_i = 1; IDEX_Rd_i = 9; IFID_Rs1_i = 9;
    for (int i = 0; i < 20; i++) runCycle("sat");
    check("sat_cnt", {28'b0, stall_cnt_o}, 32'(CNT_MAX));

    // Random traffic with small register indices to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      rst_i          = ($urandom_range(0, 99) == 0);
      start_i        = ($urandom_range(0, 3) == 0);
      IDEX_MemRead_i = $urandom_range(0, 1);
      IDEX_Rd_i      = 5'($urandom_range(0, 3));
      IFID_Rs1_i     = 5'($urandom_range(0, 3));
      IFID_Rs2_i     = 5'($urandom_range(0, 3));
      BranchTaken_i  = ($urandom_range(0, 3) == 0);
      MemReq_i       = ($urandom_range(0, 3) == 0);
      MemAck_i       = $urandom_range(0, 1);
      runCycle("rand");
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
